sparc_exu_reg_rdport: RTL and testbench

Thread-indexed read port for the EXU per-thread architectural state registers, such as small per-thread control fields. It holds one SIZE-bit copy per strand, written at W with the existing wen/thr convention. It returns the copy for a requested thread through a two-entry output buffer with valid/ack flow control. It is the read side of the per-thread register: consumers in the E/M stages issue a thread request and pop the result when ready.

---
 rtl/sparc_exu_reg_rdport_pkg.sv | 17 +
 rtl/sparc_exu_reg_rdbuf.sv | 47 ++++
 rtl/sparc_exu_reg_rdport.sv | 77 +++++++
 tb/tb_sparc_exu_reg_rdport.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_reg_rdport_pkg.sv
// Shared definitions for the EXU per-thread register read/write sides:
// default strand count, one-hot thread encodings and a one-hot check.
package sparc_exu_reg_rdport_pkg;

  localparam int NTHR_DEF = 4;

  localparam logic [NTHR_DEF-1:0] THR0 = 4'b0001;
  localparam logic [NTHR_DEF-1:0] THR1 = 4'b0010;
  localparam logic [NTHR_DEF-1:0] THR2 = 4'b0100;
  localparam logic [NTHR_DEF-1:0] THR3 = 4'b1000;

  // Thread vectors up to 32 strands wide; callers zero-extend.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sparc_exu_reg_rdbuf.sv
// Two-entry output buffer for the per-thread read port. Entries enter at the
// tail on push and leave from the head on pop; count is exposed for debug.
module sparc_exu_reg_rdbuf #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         arst_l,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         vld,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         head;
  logic         tail;
  logic         push_ok;
  logic         pop_ok;

  // Push while full and pop while empty are dropped.
  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);
  assign tail    = head ^ count[0];

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) mem[tail] <= push_data;
      if (pop_ok) head <= ~head;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign vld  = (count != 2'd0);
  assign data = vld ? mem[head] : '0;

endmodule

// File: rtl/sparc_exu_reg_rdport.sv
// Thread-indexed read port for per-thread EXU state: one SIZE-bit register
// per strand written at W, read through a two-entry valid/ack buffer.
module sparc_exu_reg_rdport
  import sparc_exu_reg_rdport_pkg::*;
#(
  parameter int SIZE = 3,
  parameter int NTHR = NTHR_DEF
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            se,
  input  logic            wen_w,
  input  logic [NTHR-1:0] thr_w,
  input  logic [SIZE-1:0] data_in_w,
  input  logic            rd_req,
  input  logic [NTHR-1:0] rd_thr,
  output logic            rd_rdy,
  output logic            data_vld,
  output logic [SIZE-1:0] data_out,
  output logic [NTHR-1:0] data_thr,
  input  logic            data_ack,
  output logic            rd_err
);

  // Handshake: a request is taken on rd_req & rd_rdy; the head entry is
  // consumed on data_vld & data_ack. rd_rdy depends only on registered count.

  logic [SIZE-1:0]      thr_q [NTHR];
  logic [SIZE-1:0]      rd_data;
  logic                 accept;
  logic [1:0]           buf_count;
  logic [SIZE+NTHR-1:0] buf_data;
  logic                 unused_se;

  assign unused_se = se;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < NTHR; i++) thr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        if (wen_w && thr_w[i]) thr_q[i] <= data_in_w;
      end
    end
  end

  // Write-first: a same-cycle write to a selected thread wins over storage.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NTHR; i++) begin
      if (rd_thr[i]) rd_data = rd_data | ((wen_w && thr_w[i]) ? data_in_w : thr_q[i]);
    end
  end

  assign rd_rdy = (buf_count != 2'd2);
  assign accept = rd_req && rd_rdy;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) rd_err <= 1'b0;
    else         rd_err <= accept && !is_onehot(32'(rd_thr));
  end

  sparc_exu_reg_rdbuf #(.W(SIZE + NTHR)) u_rdbuf (
    .clk       (clk),
    .arst_l    (arst_l),
    .push      (accept),
    .push_data ({rd_data, rd_thr}),
    .pop       (data_ack),
    .vld       (data_vld),
    .data      (buf_data),
    .count     (buf_count)
  );

  assign data_out = buf_data[SIZE+NTHR-1:NTHR];
  assign data_thr = buf_data[NTHR-1:0];

endmodule

// File: tb/tb_sparc_exu_reg_rdport.sv
// Directed bench for sparc_exu_reg_rdport: one task per scenario, inline checks.
module tb_sparc_exu_reg_rdport;
  import sparc_exu_reg_rdport_pkg::*;

  logic       clk = 1'b0;
  logic       arst_l = 1'b0;
  logic       se = 1'b0;
  logic       wen_w = 1'b0;
  logic [3:0] thr_w = '0;
  logic [2:0] data_in_w = '0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_thr = '0;
  logic       rd_rdy;
  logic       data_vld;
  logic [2:0] data_out;
  logic [3:0] data_thr;
  logic       data_ack = 1'b0;
  logic       rd_err;

  int n_cmp = 0;
  int n_fail = 0;

  sparc_exu_reg_rdport #(.SIZE(3), .NTHR(4)) dut (
    .clk       (clk),
    .arst_l    (arst_l),
    .se        (se),
    .wen_w     (wen_w),
    .thr_w     (thr_w),
    .data_in_w (data_in_w),
    .rd_req    (rd_req),
    .rd_thr    (rd_thr),
    .rd_rdy    (rd_rdy),
    .data_vld  (data_vld),
    .data_out  (data_out),
    .data_thr  (data_thr),
    .data_ack  (data_ack),
    .rd_err    (rd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] t, input logic [2:0] d);
    wen_w = 1'b1; thr_w = t; data_in_w = d;
    step();
    wen_w = 1'b0; thr_w = '0; data_in_w = '0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b want=0", data_vld); end
    n_cmp++; if (data_out !== 3'b000) begin n_fail++; $display("FAIL reset_data got=%b want=000", data_out); end
    n_cmp++; if (data_thr !== 4'b0000) begin n_fail++; $display("FAIL reset_thr got=%b want=0000", data_thr); end
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", rd_err); end
    arst_l = 1'b1;
    step();
    n_cmp++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b want=1", rd_rdy); end
  endtask

  task automatic test_basic_read();
    do_write(THR2, 3'b101);
    rd_req = 1'b1; rd_thr = THR2;
    step();
    rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (data_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld got=%b want=1", data_vld); end
    n_cmp++; if (data_out !== 3'b101) begin n_fail++; $display("FAIL basic_data got=%b want=101", data_out); end
    n_cmp++; if (data_thr !== 4'b0100) begin n_fail++; $display("FAIL basic_thr got=%b want=0100", data_thr); end
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b want=0", rd_err); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL basic_pop_vld got=%b want=0", data_vld); end
  endtask

  task automatic test_bypass();
    wen_w = 1'b1; thr_w = THR1; data_in_w = 3'b110;
    rd_req = 1'b1; rd_thr = THR1;
    step();
    wen_w = 1'b0; thr_w = '0; data_in_w = '0; rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (data_out !== 3'b110) begin n_fail++; $display("FAIL bypass_data got=%b want=110", data_out); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    rd_req = 1'b1; rd_thr = THR1;
    step();
    rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (data_out !== 3'b110) begin n_fail++; $display("FAIL bypass_later got=%b want=110", data_out); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
  endtask

  task automatic test_full();
    do_write(THR0, 3'b011);
    rd_req = 1'b1; rd_thr = THR2; step();
    rd_thr = THR1; step();
    n_cmp++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy got=%b want=0", rd_rdy); end
    rd_thr = THR0; step();
    n_cmp++; if (data_out !== 3'b101) begin n_fail++; $display("FAIL full_head got=%b want=101", data_out); end
    n_cmp++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL full_hold_rdy got=%b want=0", rd_rdy); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    n_cmp++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rdy_back got=%b want=1", rd_rdy); end
    n_cmp++; if (data_out !== 3'b110) begin n_fail++; $display("FAIL full_second got=%b want=110", data_out); end
    step();
    rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL full_third_taken got=%b want=0", rd_rdy); end
    data_ack = 1'b1; step();
    n_cmp++; if (data_out !== 3'b011) begin n_fail++; $display("FAIL full_third_data got=%b want=011", data_out); end
    n_cmp++; if (data_thr !== 4'b0001) begin n_fail++; $display("FAIL full_third_thr got=%b want=0001", data_thr); end
    step(); data_ack = 1'b0;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL full_drain got=%b want=0", data_vld); end
  endtask

  task automatic test_err();
    rd_req = 1'b1; rd_thr = 4'b0000; step(); rd_req = 1'b0;
    n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_zero_pulse got=%b want=1", rd_err); end
    n_cmp++; if (data_out !== 3'b000) begin n_fail++; $display("FAIL err_zero_data got=%b want=000", data_out); end
    n_cmp++; if (data_vld !== 1'b1) begin n_fail++; $display("FAIL err_zero_vld got=%b want=1", data_vld); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_zero_once got=%b want=0", rd_err); end
    do_write(THR0, 3'b001);
    do_write(THR1, 3'b010);
    rd_req = 1'b1; rd_thr = 4'b0011; step(); rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (data_out !== 3'b011) begin n_fail++; $display("FAIL err_multi_data got=%b want=011", data_out); end
    n_cmp++; if (data_thr !== 4'b0011) begin n_fail++; $display("FAIL err_multi_thr got=%b want=0011", data_thr); end
    n_cmp++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_multi_pulse got=%b want=1", rd_err); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    n_cmp++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_multi_once got=%b want=0", rd_err); end
  endtask

  task automatic test_simul_push_pop();
    rd_req = 1'b1; rd_thr = THR2; step();
    rd_thr = THR0; data_ack = 1'b1; step();
    rd_req = 1'b0; rd_thr = '0; data_ack = 1'b0;
    n_cmp++; if (data_vld !== 1'b1) begin n_fail++; $display("FAIL simul_vld got=%b want=1", data_vld); end
    n_cmp++; if (data_out !== 3'b001) begin n_fail++; $display("FAIL simul_data got=%b want=001", data_out); end
    n_cmp++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL simul_count1 got=%b want=1", rd_rdy); end
    data_ack = 1'b1; step(); data_ack = 1'b0;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL simul_drain got=%b want=0", data_vld); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_v [4];
    exp_v[0] = 3'b001; exp_v[1] = 3'b010; exp_v[2] = 3'b101; exp_v[3] = 3'b111;
    do_write(THR3, 3'b111);
    data_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_thr = 4'(1 << i);
      step();
      n_cmp++; if (data_out !== exp_v[i] || data_vld !== 1'b1 || rd_rdy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d got=%b/%b/%b want=%b/1/1", i, data_out, data_vld, rd_rdy, exp_v[i]);
      end
    end
    rd_req = 1'b0; rd_thr = '0;
    step(); data_ack = 1'b0;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b want=0", data_vld); end
  endtask

  task automatic test_reset_mid();
    rd_req = 1'b1; rd_thr = THR2; step();
    rd_thr = THR3; step(); rd_req = 1'b0; rd_thr = '0;
    n_cmp++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got=%b want=0", rd_rdy); end
    #2 arst_l = 1'b0;
    #1;
    n_cmp++; if (data_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld got=%b want=0", data_vld); end
    n_cmp++; if (data_out !== 3'b000) begin n_fail++; $display("FAIL rstmid_data got=%b want=000", data_out); end
    #3 arst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_thr = 4'(1 << i); step(); rd_req = 1'b0; rd_thr = '0;
      n_cmp++; if (data_out !== 3'b000 || data_vld !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_read_%0d got=%b/%b want=000/1", i, data_out, data_vld);
      end
      data_ack = 1'b1; step(); data_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_bypass();
    test_full();
    test_err();
    test_simul_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
